// File: rtl/instr_sequencer.sv
// Program-store sequencer that feeds the 4-register bus processor one instruction
// at a time, handshaking on w/T0 and advancing on Done, with a watchdog on EXEC.
module instr_sequencer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [13:0]   load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          T0,
    input  logic          Done,
    output logic [7:0]    Data,
    output logic          w,
    output logic [1:0]    F,
    output logic [1:0]    Rx,
    output logic [1:0]    Ry,
    output logic          busy,
    output logic          finished,
    output logic          error,
    output logic [AW-1:0] pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_EXEC,
        S_FIN,
        S_ERROR
    } state_e;

    localparam logic [AW-1:0] PC_ZERO   = '0;
    localparam logic [AW-1:0] PC_ONE    = AW'(1);
    localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);
    localparam logic [7:0]    WDOG_LAST = 8'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [13:0]   instr_q, instr_d;
    logic          w_q, w_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    wdog_q, wdog_d;

    logic [13:0]   mem_q [DEPTH];
    logic          store_open;
    logic          last_instr;
    logic [AW-1:0] pc_next;

    // Writes are locked out while an instruction is in flight so the word the
    // processor is executing can never change underneath it.
    assign store_open = (state_q == S_IDLE) || (state_q == S_FIN) || (state_q == S_ERROR);

    // NOTE: the program store has no reset; contents must survive Reset, and
    // leaving it unreset also lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (load_en && store_open) begin
            mem_q[load_addr] <= load_data;
        end
    end

    assign pc_next    = pc_q + PC_ONE;
    assign last_instr = ({1'b0, pc_q} == (prog_len - LEN_ONE));

    // NOTE: every variable gets its hold value before the case statement, so no
    // path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        w_d     = w_q;
        pc_d    = pc_q;
        wdog_d  = wdog_q;

        unique case (state_q)
            S_IDLE, S_FIN, S_ERROR: begin
                w_d = 1'b0;
                if (start && (prog_len != '0)) begin
                    pc_d    = PC_ZERO;
                    instr_d = mem_q[PC_ZERO];
                    w_d     = 1'b1;
                    state_d = S_ISSUE;
                end
            end

            // Done may still be high from the previous instruction here, so
            // only the w/T0 handshake is looked at.
            S_ISSUE: begin
                w_d = 1'b1;
                if (w_q && T0) begin
                    w_d     = 1'b0;
                    wdog_d  = '0;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                w_d = 1'b0;
                if (Done) begin
                    if (last_instr) begin
                        state_d = S_FIN;
                    end else begin
                        pc_d    = pc_next;
                        instr_d = mem_q[pc_next];
                        w_d     = 1'b1;
                        state_d = S_ISSUE;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end

            default: begin
                w_d     = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            w_q     <= 1'b0;
            pc_q    <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            w_q     <= w_d;
            pc_q    <= pc_d;
            wdog_q  <= wdog_d;
        end
    end

    assign Data     = instr_q[7:0];
    assign Ry       = instr_q[9:8];
    assign Rx       = instr_q[11:10];
    assign F        = instr_q[13:12];
    assign w        = w_q;
    assign pc       = pc_q;
    assign busy     = (state_q == S_ISSUE) || (state_q == S_EXEC);
    assign finished = (state_q == S_FIN);
    assign error    = (state_q == S_ERROR);

    // w outside ISSUE would let the processor load the same word twice.
    a_w_only_in_issue : assert property (
        @(posedge clk) disable iff (Reset) (state_q != S_ISSUE) |-> !w_q
    );

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a small behavioural model of the bus
// processor plus manual T0/Done control for the handshake corner cases.
module tb_instr_sequencer;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          Reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [13:0]   load_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          T0;
    logic          Done;
    logic [7:0]    Data;
    logic          w;
    logic [1:0]    F, Rx, Ry;
    logic          busy, finished, error;
    logic [AW-1:0] pc;

    logic use_model;
    logic t0_man, done_man;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    instr_sequencer #(.DEPTH(16), .AW(AW), .TIMEOUT(15)) dut (
        .clk(clk), .Reset(Reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .start(start), .T0(T0),
        .Done(Done), .Data(Data), .w(w), .F(F), .Rx(Rx), .Ry(Ry), .busy(busy),
        .finished(finished), .error(error), .pc(pc)
    );

    // Processor model: free-running step counter, cleared on Done.
    logic [1:0] p_cnt;
    logic       p_busy;
    logic [1:0] p_f, p_rx, p_ry;
    logic [7:0] p_data;
    logic [7:0] p_r [4];
    logic       m_t0, m_done;

    assign m_t0   = (p_cnt == 2'd0);
    assign m_done = p_busy && ((!p_f[1] && p_cnt == 2'd1) || (p_f[1] && p_cnt == 2'd3));
    assign T0     = use_model ? m_t0 : t0_man;
    assign Done   = use_model ? m_done : done_man;

    always_ff @(posedge clk) begin
        if (Reset) begin
            p_cnt  <= '0;
            p_busy <= 1'b0;
            for (int i = 0; i < 4; i++) p_r[i] <= '0;
        end else begin
            if (m_done) begin
                p_cnt  <= '0;
                p_busy <= 1'b0;
                case (p_f)
                    2'b00: p_r[p_rx] <= p_data;
                    2'b01: p_r[p_rx] <= p_r[p_ry];
                    2'b10: p_r[p_rx] <= p_r[p_rx] + p_r[p_ry];
                    default: p_r[p_rx] <= p_r[p_rx] - p_r[p_ry];
                endcase
            end else begin
                p_cnt <= p_cnt + 2'd1;
            end
            if (use_model && w && m_t0 && !p_busy) begin
                p_busy <= 1'b1;
                p_f    <= F;
                p_rx   <= Rx;
                p_ry   <= Ry;
                p_data <= Data;
            end
        end
    end

    int acc_total = 0;
    always_ff @(posedge clk) begin
        if (w && T0) acc_total <= acc_total + 1;
    end

    typedef struct {
        logic [13:0] word;
        logic [1:0]  dst;
        logic [7:0]  exp_r;
    } vec_t;

    function automatic logic [13:0] mk(logic [1:0] f, logic [1:0] rx, logic [1:0] ry, logic [7:0] d);
        return {f, rx, ry, d};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic load_word(int addr, logic [13:0] word);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = word;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic pulse_start(int len);
        prog_len = (AW+1)'(len);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(string name, int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (finished || error) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(name, 32'(got), 32'd1);
    endtask

    task automatic man_exec();
        t0_man = 1'b1;
        @(negedge clk);
        t0_man   = 1'b0;
        done_man = 1'b1;
        @(negedge clk);
        done_man = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        int  base;
        bit  seen;

        vecs[0] = '{mk(2'd0, 2'd1, 2'd0, 8'h5A), 2'd1, 8'h5A};
        vecs[1] = '{mk(2'd0, 2'd2, 2'd0, 8'h13), 2'd2, 8'h13};
        vecs[2] = '{mk(2'd2, 2'd1, 2'd2, 8'h00), 2'd1, 8'h6D};
        vecs[3] = '{mk(2'd3, 2'd1, 2'd2, 8'h00), 2'd1, 8'h5A};
        vecs[4] = '{mk(2'd1, 2'd3, 2'd1, 8'hFF), 2'd3, 8'h5A};
        vecs[5] = '{mk(2'd3, 2'd0, 2'd3, 8'h00), 2'd0, 8'hA6};

        Reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        prog_len = '0; start = 1'b0; use_model = 1'b0; t0_man = 1'b0; done_man = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_w", 32'(w), 32'd0);
        check("reset_instr", 32'({F, Rx, Ry, Data}), 32'd0);
        check("reset_status", 32'({busy, finished, error}), 32'd0);
        check("reset_pc", 32'(pc), 32'd0);
        Reset = 1'b0;
        @(negedge clk);

        // Single-instruction runs against the processor model.
        use_model = 1'b1;
        for (int i = 0; i < 6; i++) begin
            load_word(0, vecs[i].word);
            base = acc_total;
            pulse_start(1);
            wait_done($sformatf("vec%0d_timeout", i), 40);
            check($sformatf("vec%0d_finished", i), 32'({finished, error, busy, w}), 32'b1000);
            check($sformatf("vec%0d_instr", i), 32'({F, Rx, Ry, Data}), 32'(vecs[i].word));
            check($sformatf("vec%0d_pc", i), 32'(pc), 32'd0);
            check($sformatf("vec%0d_accepts", i), 32'(acc_total - base), 32'd1);
            check($sformatf("vec%0d_reg", i), 32'(p_r[vecs[i].dst]), 32'(vecs[i].exp_r));
        end

        // Stale Done across ISSUE; operands held through EXEC.
        use_model = 1'b0;
        load_word(0, mk(2'd0, 2'd1, 2'd0, 8'h5A));
        load_word(1, mk(2'd1, 2'd2, 2'd1, 8'hC3));
        done_man = 1'b1;
        pulse_start(2);
        check("stale_issue_w", 32'(w), 32'd1);
        repeat (3) @(negedge clk);
        check("stale_no_advance", 32'({w, pc}), 32'({1'b1, 4'd0}));
        t0_man = 1'b1;
        @(negedge clk);
        t0_man = 1'b0; done_man = 1'b0;
        check("accept_w_low", 32'({w, busy}), 32'b01);
        repeat (3) @(negedge clk);
        check("exec_hold", 32'({w, Rx, Data}), 32'({1'b0, 2'd1, 8'h5A}));
        done_man = 1'b1;
        @(negedge clk);
        check("advance_pc1", 32'({w, pc, Data}), 32'({1'b1, 4'd1, 8'hC3}));
        @(negedge clk);
        check("stale_pc1_hold", 32'({w, pc}), 32'({1'b1, 4'd1}));
        t0_man = 1'b1;
        @(negedge clk);
        t0_man = 1'b0;
        @(negedge clk);
        done_man = 1'b0;
        check("two_instr_fin", 32'({finished, w, pc, F, Ry}), 32'({1'b1, 1'b0, 4'd1, 2'd1, 2'd1}));

        // Watchdog: no Done after acceptance.
        load_word(0, mk(2'd0, 2'd3, 2'd0, 8'h77));
        pulse_start(1);
        check("wd_issue", 32'(w), 32'd1);
        t0_man = 1'b1;
        @(negedge clk);
        t0_man = 1'b0;
        repeat (14) @(negedge clk);
        check("wd_before", 32'({error, busy, w}), 32'b010);
        @(negedge clk);
        check("wd_error", 32'({error, busy, w}), 32'b100);
        pulse_start(1);
        check("wd_restart", 32'({pc, w, busy, error}), 32'({4'd0, 3'b110}));
        man_exec();
        check("wd_restart_fin", 32'(finished), 32'd1);

        // Three-instruction program on the model: R0 = 3 + 4.
        use_model = 1'b1;
        load_word(0, mk(2'd0, 2'd0, 2'd0, 8'h03));
        load_word(1, mk(2'd0, 2'd1, 2'd0, 8'h04));
        load_word(2, mk(2'd2, 2'd0, 2'd1, 8'h00));
        base = acc_total;
        pulse_start(3);
        wait_done("prog3_timeout", 200);
        check("prog3_r0", 32'(p_r[0]), 32'h07);
        check("prog3_status", 32'({finished, pc}), 32'({1'b1, 4'd2}));
        check("prog3_accepts", 32'(acc_total - base), 32'd3);

        // Reset while executing the add at pc=2.
        pulse_start(3);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (pc == 4'd2 && busy && !w) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_exec_pc2", 32'(seen), 32'd1);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        use_model = 1'b0;
        check("midrun_reset", 32'({w, pc, busy, finished}), 32'd0);

        // Store survives reset; loads while busy are dropped.
        pulse_start(3);
        check("mem_kept0", 32'({F, Rx, Data}), 32'({2'd0, 2'd0, 8'h03}));
        load_word(0, mk(2'd3, 2'd3, 2'd3, 8'hEE));
        man_exec();
        check("mem_kept1", 32'({pc, Data}), 32'({4'd1, 8'h04}));
        man_exec();
        man_exec();
        check("busy_load_fin", 32'(finished), 32'd1);
        pulse_start(1);
        check("busy_load_ignored", 32'({F, Rx, Ry, Data}), 32'(mk(2'd0, 2'd0, 2'd0, 8'h03)));
        man_exec();

        // start with prog_len=0 from IDLE.
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        pulse_start(0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen |= w;
            @(negedge clk);
        end
        check("len0_no_w", 32'(seen), 32'd0);
        check("len0_idle", 32'({busy, finished, error}), 32'd0);

        // prog_len = DEPTH runs every entry once.
        use_model = 1'b1;
        for (int i = 0; i < 16; i++) load_word(i, mk(2'd0, 2'(i % 4), 2'd0, 8'(i * 3 + 1)));
        base = acc_total;
        pulse_start(16);
        wait_done("full_timeout", 600);
        check("full_accepts", 32'(acc_total - base), 32'd16);
        check("full_status", 32'({finished, pc}), 32'({1'b1, 4'd15}));
        check("full_r3", 32'(p_r[3]), 32'h2E);
        check("full_r0", 32'(p_r[0]), 32'h25);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream feeder for the 4-register bus processor (ports Data, w, F, Rx, Ry, Done, T).
- Holds a small loadable program store and issues one instruction at a time.
- Asserts w until the processor latches the instruction at T[0], then waits for Done, then advances.
- Provides run/halt status and a watchdog for a hung processor.

Parameters:
- DEPTH, 16, program store entries (power of 2).
- AW, 4, address width; log2(DEPTH).
- TIMEOUT, 15, maximum cycles in EXEC before ERROR; range 4..255.

Ports:
- clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- load_en  in  1  write program word this cycle.
- load_addr  in  AW  program word address.
- load_data  in  14  {F[1:0], Rx[1:0], Ry[1:0], Data[7:0]}, bit 13 = F[1].
- prog_len  in  AW+1  number of instructions to run, 0..DEPTH.
- start  in  1  one-cycle run request.
- T0  in  1  processor T[0].
- Done  in  1  processor Done.
- Data  out  8  immediate operand to processor.
- w  out  1  instruction-valid to processor.
- F  out  2  opcode.
- Rx  out  2  destination register.
- Ry  out  2  source register.
- busy  out  1  high in ISSUE or EXEC.
- finished  out  1  high in FIN.
- error  out  1  high in ERROR.
- pc  out  AW  address of the current instruction.

Behaviour:
- Program store:
  - Synchronous write on load_en, honoured only in IDLE, FIN or ERROR; ignored while busy.
  - Reads are asynchronous. Contents are not cleared by Reset.
- Reset outputs: w=0, Data=0, F=0, Rx=0, Ry=0, busy=0, finished=0, error=0, pc=0. State = IDLE; watchdog = 0.
- Reset mid-run aborts immediately: w=0 on the next edge, and no further instruction is issued.
- FSM states: IDLE, ISSUE, EXEC, FIN, ERROR.
  - IDLE: on start with prog_len≠0, set pc=0, latch mem[0] into the output registers, go to ISSUE. start with prog_len=0 is ignored.
  - ISSUE: w=1. At the edge where w=1 and T0=1, the processor loads the instruction; go to EXEC, set w=0, clear the watchdog.
  - EXEC: w=0. Hold Data/F/Rx/Ry stable for the instruction's whole execution (Extern samples Data at T1).
    - Done is ignored while in ISSUE; it may be stale from the previous FuncReg there.
    - On Done=1: if pc == prog_len-1, go to FIN. Otherwise pc+1, latch mem[pc+1], go to ISSUE.
    - If the watchdog reaches TIMEOUT without Done, go to ERROR.
  - FIN and ERROR: outputs hold their last values with w=0. start re-runs from pc=0 (same as IDLE). A new load is allowed.
- Timing and latency:
  - w is registered.
  - Issue latency from entering ISSUE to acceptance is 1..4 cycles, depending on the processor counter phase.
  - Minimum per-instruction cycle is accept edge → Done (1 cycle for load/move, 3 for add/sub) → next ISSUE.
- start received in ISSUE or EXEC is ignored.
- w must never be high during a T0 cycle after acceptance of the same instruction. This prevents double-loading.
- pc wraps naturally within AW bits. prog_len=DEPTH runs every entry once.

Test Plan:
- Load mem[0]={00,01,00,0x5A}, prog_len=1, start; model T0 every 4th cycle, Done at accept+1 → exactly one cycle with w&T0; Data=0x5A, Rx=01 held through EXEC; finished=1 after Done; w=0 thereafter.
- Program {load R0=3; load R1=4; add R0,R1} (F=10), prog_len=3; drive the real processor → R0=7, finished=1, pc=2, three w&T0 acceptances total.
- Done held high from the previous instruction while entering ISSUE → no pc advance until after acceptance.
- Processor Done tied 0, TIMEOUT=15 → error=1 exactly 15 cycles after acceptance; busy=0; a subsequent start restarts at pc=0.
- Reset asserted in EXEC at pc=2 → next edge w=0, pc=0, busy=0; program memory still reads its old values.
- load_en during busy → store unchanged. start with prog_len=0 → stays IDLE, w never asserted.
